// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer in front of the single-port unified
// memory: requester 0 is the core, requester 1 the loader/debug port.
module mem_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       winner;
  logic       ptr;
  logic [2:0] cnt;
  logic       we_q;
  logic       sel;
  logic       any_req;
  logic       first_cyc;
  logic       last_cyc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes, gnt and done are decoded from state so an asynchronous reset
  // removes them at once, without waiting for a clock.
  always_comb begin
    state_nxt = state;
    any_req   = req0 | req1;
    sel       = (req0 & req1) ? ptr : req1;
    first_cyc = (cnt == CNT_INIT);
    last_cyc  = (cnt == 3'd0);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        gnt0      = first_cyc & ~winner;
        gnt1      = first_cyc & winner;
        mem_read  = ~we_q;
        mem_write = we_q;
        if (last_cyc) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        done0     = ~winner;
        done1     = winner;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner    <= 1'b0;
      ptr       <= 1'b0;
      cnt       <= 3'd0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner    <= sel;
            cnt       <= CNT_INIT;
            we_q      <= sel ? we1 : we0;
            mem_addr  <= sel ? addr1 : addr0;
            mem_wdata <= sel ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          if (!last_cyc) begin
            cnt <= cnt - 3'd1;
          end else if (!we_q) begin
            rdata <= mem_rdata;
          end
        end
        RESP: begin
          ptr <= ~winner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3 share
// the stimulus; a transaction-level model predicts grants, completions and data.
module tb_mem_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct packed {
    int          port;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;

  logic [1:0] gnt0, gnt1, done0, done1, busy, mem_read, mem_write;
  logic [DW-1:0] rdata [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0)) u_dut_l1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .rdata(rdata[0]), .busy(busy[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) u_dut_l3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .rdata(rdata[1]), .busy(busy[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [DW-1:0] init_val(input int a);
    return 8'(a * 29 + 7);
  endfunction

  // Memory: read data is only meaningful in the last strobe cycle, junk otherwise.
  logic [DW-1:0] mem [2][32];
  int  rd_run [2];
  bit  mem_init = 1'b0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2; i++) begin
        rd_run[i] = 0;
        for (int a = 0; a < 32; a++) mem[i][a] = init_val(a);
      end
      mem_init = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (rst && mem_write[i]) mem[i][mem_addr[i]] = mem_wdata[i];
      if (rst && mem_read[i]) rd_run[i] = rd_run[i] + 1;
      else rd_run[i] = 0;
      mem_rdata[i] = (rd_run[i] == lat_of(i)) ? mem[i][mem_addr[i]] : 8'($urandom);
    end
  end

  // Reference model: accesses are serial transactions; one accepted per free edge.
  exp_t gq [2][$];
  exp_t dq [2][$];
  logic [DW-1:0] ref_mem [2][32];
  bit   ref_init = 1'b0;
  bit   act [2];
  int   act_t [2];
  logic act_we [2];
  logic [AW-1:0] last_addr [2];
  logic [DW-1:0] last_wd [2];
  int   ptr_m [2];
  int   next_edge [2];
  always @(posedge clk) begin
    exp_t e;
    int w;
    cyc = cyc + 1;
    if (!ref_init) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 32; a++) ref_mem[i][a] = init_val(a);
      ref_init = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        act[i] = 1'b0; act_t[i] = 0; act_we[i] = 1'b0; ptr_m[i] = 0;
        next_edge[i] = 0; last_addr[i] = '0; last_wd[i] = '0;
      end else if (cyc >= next_edge[i] && (req0 || req1)) begin
        w = (req0 && req1) ? ptr_m[i] : (req1 ? 1 : 0);
        e.port  = w;
        e.we    = (w == 1) ? we1 : we0;
        e.addr  = (w == 1) ? addr1 : addr0;
        e.wdata = (w == 1) ? wdata1 : wdata0;
        e.t     = cyc;
        e.rd    = ref_mem[i][e.addr];
        if (e.we) ref_mem[i][e.addr] = e.wdata;
        gq[i].push_back(e);
        dq[i].push_back(e);
        ptr_m[i] = 1 - w;
        next_edge[i] = cyc + lat_of(i) + 2;
        act[i] = 1'b1; act_t[i] = cyc; act_we[i] = e.we;
        last_addr[i] = e.addr; last_wd[i] = e.wdata;
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s lat%0d cyc=%0d got=%0h want=%0h", nm, lat_of(inst), cyc, got, want);
    end
  endtask

  // Monitor: consumes predicted gnt/done events as the DUTs present them.
  int ghead [2] = '{0, 0};
  int dhead [2] = '{0, 0};
  logic [DW-1:0] exp_rd [2] = '{8'h00, 8'h00};
  always @(negedge clk or negedge rst) begin
    exp_t e;
    int L;
    bit in_acc, in_busy;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        chk("rst_outs", i, {gnt0[i], gnt1[i], done0[i], done1[i], busy[i], mem_read[i], mem_write[i]}, 32'd0);
        chk("rst_rdata", i, 32'(rdata[i]), 32'd0);
        chk("rst_maddr", i, 32'(mem_addr[i]), 32'd0);
        chk("rst_mwdata", i, 32'(mem_wdata[i]), 32'd0);
        ghead[i] = gq[i].size();
        dhead[i] = dq[i].size();
        exp_rd[i] = '0;
      end else begin
        L = lat_of(i);
        in_acc  = act[i] && cyc >= act_t[i] && cyc < act_t[i] + L;
        in_busy = act[i] && cyc >= act_t[i] && cyc <= act_t[i] + L;
        chk("busy", i, 32'(busy[i]), 32'(in_busy));
        chk("mem_read", i, 32'(mem_read[i]), 32'(in_acc && !act_we[i]));
        chk("mem_write", i, 32'(mem_write[i]), 32'(in_acc && act_we[i]));
        chk("mem_addr", i, 32'(mem_addr[i]), 32'(last_addr[i]));
        chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(last_wd[i]));
        chk("gnt_excl", i, 32'(gnt0[i] & gnt1[i]), 32'd0);
        chk("done_excl", i, 32'(done0[i] & done1[i]), 32'd0);
        if (gnt0[i] || gnt1[i]) begin
          if (ghead[i] < gq[i].size()) begin
            e = gq[i][ghead[i]];
            ghead[i] = ghead[i] + 1;
            chk("gnt_port", i, 32'(gnt1[i]), 32'(e.port));
            chk("gnt_cyc", i, cyc, e.t);
          end else begin
            total = total + 1; bad = bad + 1;
            $display("FAIL gnt_unexpected lat%0d cyc=%0d got=gnt want=none", L, cyc);
          end
        end
        if (ghead[i] < gq[i].size() && gq[i][ghead[i]].t <= cyc) begin
          total = total + 1; bad = bad + 1;
          $display("FAIL gnt_missing lat%0d cyc=%0d got=none want=gnt%0d", L, cyc, gq[i][ghead[i]].port);
          ghead[i] = ghead[i] + 1;
        end
        if (done0[i] || done1[i]) begin
          if (dhead[i] < dq[i].size()) begin
            e = dq[i][dhead[i]];
            dhead[i] = dhead[i] + 1;
            chk("done_port", i, 32'(done1[i]), 32'(e.port));
            chk("done_cyc", i, cyc, e.t + L);
            if (!e.we) exp_rd[i] = e.rd;
          end else begin
            total = total + 1; bad = bad + 1;
            $display("FAIL done_unexpected lat%0d cyc=%0d got=done want=none", L, cyc);
          end
        end
        if (dhead[i] < dq[i].size() && dq[i][dhead[i]].t + L <= cyc) begin
          total = total + 1; bad = bad + 1;
          $display("FAIL done_missing lat%0d cyc=%0d got=none want=done%0d", L, cyc, dq[i][dhead[i]].port);
          dhead[i] = dhead[i] + 1;
        end
        chk("rdata", i, 32'(rdata[i]), 32'(exp_rd[i]));
      end
    end
  end

  task automatic pulse(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // Both held: alternating grants from ptr=0.
    repeat (24) @(posedge clk);
    #1 idle(12);
    pulse(1'b0, 1'b1, 5'h03, 8'hA5); idle(8);
    pulse(1'b1, 1'b0, 5'h03, 8'h00); idle(8);
    pulse(1'b1, 1'b0, 5'h1F, 8'h00); idle(8);
    pulse(1'b0, 1'b1, 5'h1F, 8'h5A); idle(8);
    pulse(1'b0, 1'b0, 5'h1F, 8'h00); idle(8);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 2) == 0);
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = 5'($urandom);
      addr1  = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
    end
    #1 idle(12);
    // Leave ptr at 1, then kill a read in its second access cycle.
    pulse(1'b0, 1'b1, 5'h02, 8'h33); idle(8);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h04;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 idle(16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
